// File: rtl/bk_adder_arbiter.sv
// bk_adder_arbiter - round-robin arbiter sharing one pipelined 5-bit adder
//
// Purpose: grants at most one of N requesters per cycle, forwards its operands
// to a single LAT-cycle adder and tags the in-flight operation so the result
// returns with the originating requester id.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   req_valid[N]             per-requester request
//   req_a/req_b[5*N]         operands, requester i at bits [5i+4:5i]
//   req_ready[N]             one-hot grant (RUN state only)
//   adder_a/adder_b[5]       operands to the adder, 0 when nothing issued
//   adder_sum[5]/adder_cout  adder result, valid LAT cycles after issue
//   rsp_valid/rsp_id         result valid and requester id
//   rsp_sum/rsp_cout         result, forced to 0 when rsp_valid=0
//   drain_req                stop issuing and empty the pipe
//   drained                  pipe empty while not running
//   busy                     any operation in flight
module bk_adder_arbiter #(
  parameter int N   = 4,
  parameter int LAT = 2,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [5*N-1:0] req_a,
  input  logic [5*N-1:0] req_b,
  output logic [N-1:0]   req_ready,
  output logic [4:0]     adder_a,
  output logic [4:0]     adder_b,
  input  logic [4:0]     adder_sum,
  input  logic           adder_cout,
  output logic           rsp_valid,
  output logic [IDW-1:0] rsp_id,
  output logic [4:0]     rsp_sum,
  output logic           rsp_cout,
  input  logic           drain_req,
  output logic           drained,
  output logic           busy
);

  typedef enum logic [1:0] {RUN, DRAIN, IDLE} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] ptr_nxt;
  logic           found;
  logic           issue;
  logic [4:0]     sel_a, sel_b;

  logic           tag_vld [LAT];
  logic [IDW-1:0] tag_id  [LAT];

  // Rotating priority scan starting at ptr; the first valid requester wins.
  always_comb begin
    int idx;
    found = 1'b0;
    grant = '0;
    sel_a = '0;
    sel_b = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = IDW'(idx);
        sel_a = req_a[5*idx +: 5];
        sel_b = req_b[5*idx +: 5];
      end
    end
  end

  assign issue     = found && (state == RUN);
  assign req_ready = issue ? (N'(1) << grant) : '0;
  assign adder_a   = issue ? sel_a : 5'd0;
  assign adder_b   = issue ? sel_b : 5'd0;
  assign ptr_nxt   = (grant == IDW'(N - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < LAT; k++) busy = busy | tag_vld[k];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (drain_req) state_nxt = DRAIN;
      // Leaves DRAIN only once the pipe is empty, regardless of drain_req.
      DRAIN:   if (!busy) state_nxt = IDLE;
      IDLE:    if (!drain_req) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      ptr   <= '0;
      for (int k = 0; k < LAT; k++) begin
        tag_vld[k] <= 1'b0;
        tag_id[k]  <= '0;
      end
    end else begin
      state <= state_nxt;
      if (issue) ptr <= ptr_nxt;
      // Stage 0 loads every cycle so idle cycles become bubbles.
      tag_vld[0] <= issue;
      tag_id[0]  <= grant;
      for (int k = 1; k < LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
    end
  end

  assign rsp_valid = tag_vld[LAT-1];
  assign rsp_id    = tag_id[LAT-1];
  assign rsp_sum   = rsp_valid ? adder_sum : 5'd0;
  assign rsp_cout  = rsp_valid ? adder_cout : 1'b0;
  assign drained   = (state != RUN) && !busy;

endmodule

// File: tb/tb_bk_adder_arbiter.sv
// tb/tb_bk_adder_arbiter.sv - directed scoreboard bench for bk_adder_arbiter
module tb_bk_adder_arbiter;

  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [5*N-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic [4:0]     adder_a, adder_b, adder_sum;
  logic           adder_cout;
  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [4:0]     rsp_sum;
  logic           rsp_cout;
  logic           drain_req, drained, busy;

  logic [4:0] op_a [N];
  logic [4:0] op_b [N];

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [5:0]     total;
  } exp_t;
  exp_t sb[$];

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[5*i +: 5] = op_a[i];
      req_b[5*i +: 5] = op_b[i];
    end
  end

  // Behavioural LAT-cycle adder standing in for the shared adder.
  logic [5:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= {1'b0, adder_a} + {1'b0, adder_b};
    for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
  end
  assign adder_sum  = apipe[LAT-1][4:0];
  assign adder_cout = apipe[LAT-1][5];

  bk_adder_arbiter #(.N(N), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .adder_a(adder_a), .adder_b(adder_b), .adder_sum(adder_sum), .adder_cout(adder_cout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .drain_req(drain_req), .drained(drained), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard sampling at the falling edge: pop responses, then record handshakes.
  task automatic sample();
    exp_t e;
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_sum", 32'(rsp_sum), 32'(e.total[4:0]));
        chk("rsp_cout", 32'(rsp_cout), 32'(e.total[5]));
      end
    end else begin
      chk("idle_rsp_data", 32'({rsp_cout, rsp_sum}), 32'd0);
    end
    if (rst) begin
      sb.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id    = IDW'(i);
          e.total = {1'b0, op_a[i]} + {1'b0, op_b[i]};
          sb.push_back(e);
          chk("adder_a", 32'(adder_a), 32'(op_a[i]));
          chk("adder_b", 32'(adder_b), 32'(op_b[i]));
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    req_valid = '0;
    drain_req = 1'b0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    cycle();
    cycle();
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_drained", 32'(drained), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // 1) single request from requester 0
    op_a[0] = 5'b00001; op_b[0] = 5'b00010;
    req_valid = 4'b0001;
    #1 chk("t1_ready", 32'(req_ready), 32'b0001);
    cycle();
    req_valid = '0;
    chk("t1_busy", 32'(busy), 32'd1);
    cycle();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_sum", 32'(rsp_sum), 32'b00011);
    cycle();
    cycle();

    // 2) carry out and all-ones sum from requester 2
    op_a[2] = 5'b11111; op_b[2] = 5'b00001;
    req_valid = 4'b0100;
    #1 chk("t2_ready_a", 32'(req_ready), 32'b0100);
    cycle();
    op_a[2] = 5'b10101; op_b[2] = 5'b01010;
    #1 chk("t2_ready_b", 32'(req_ready), 32'b0100);
    cycle();
    req_valid = '0;
    chk("t2_rsp_cout", 32'({rsp_valid, rsp_cout, rsp_sum}), 32'b1_1_00000);
    cycle();
    chk("t2_rsp_sum", 32'({rsp_valid, rsp_cout, rsp_sum}), 32'b1_0_11111);
    cycle();
    cycle();

    // 3) all requesters valid from reset: strict rotation, no bubbles
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    req_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) begin
        op_a[i] = 5'($urandom_range(0, 31));
        op_b[i] = 5'($urandom_range(0, 31));
      end
      #1 chk("t3_grant", 32'(req_ready), 32'(1 << (c % N)));
      if (c >= LAT) chk("t3_no_bubble", 32'(rsp_valid), 32'd1);
      cycle();
    end
    req_valid = '0;
    cycle();
    cycle();
    cycle();

    // 4) requesters 1 and 3 with ptr=2: 3, 1, 3
    req_valid = 4'b1010;
    #1 chk("t4_grant_3a", 32'(req_ready), 32'b1000);
    cycle();
    #1 chk("t4_grant_1", 32'(req_ready), 32'b0010);
    cycle();
    #1 chk("t4_grant_3b", 32'(req_ready), 32'b1000);
    cycle();
    req_valid = '0;
    cycle();
    cycle();
    cycle();

    // 5) drain with two operations in flight (ptr=0)
    op_a[0] = 5'd7;  op_b[0] = 5'd9;
    op_a[1] = 5'd30; op_b[1] = 5'd3;
    req_valid = 4'b0011;
    cycle();
    cycle();
    req_valid = '0;
    drain_req = 1'b1;
    chk("t5_busy", 32'(busy), 32'd1);
    cycle();
    req_valid = 4'b1111;
    waited = 0;
    while (!drained && waited < 10) begin
      #1 chk("t5_no_grant", 32'(req_ready), 32'd0);
      cycle();
      waited++;
    end
    chk("t5_drained", 32'(drained), 32'd1);
    chk("t5_busy_clear", 32'(busy), 32'd0);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);
    cycle();
    chk("t5_idle_no_grant", 32'(req_ready), 32'd0);
    drain_req = 1'b0;
    cycle();
    #1 chk("t5_resume", 32'(req_ready), 32'b0100);
    cycle();
    req_valid = '0;
    cycle();
    cycle();
    cycle();

    // 6) reset right after an issue discards the result and clears ptr
    op_a[2] = 5'b01111; op_b[2] = 5'b00101;
    req_valid = 4'b0100;
    cycle();
    req_valid = '0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("t6_rsp_dropped", 32'(rsp_valid), 32'd0);
      cycle();
    end
    chk("t6_busy", 32'(busy), 32'd0);
    op_a[1] = 5'd4; op_b[1] = 5'd5;
    req_valid = 4'b1010;
    #1 chk("t6_lowest_grant", 32'(req_ready), 32'b0010);
    cycle();
    req_valid = '0;
    cycle();
    cycle();
    cycle();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
